// File: rtl/bc_1553_scheduler.sv
// bc_1553_scheduler
//
// Bus-controller message sequencer sitting between the host register/DMA
// logic and the 1553 encode/decode core. One command word is accepted at a
// time. The command and any BC->RT data words go out on the transmit stream.
// The RT status word and any RT->BC data words are then supervised on the
// receive stream, under a response timeout. Every message that is not aborted
// by reset ends with exactly one result record.
//
// Ports
//   aclk, arstn                      clock (rising edge), async active-low reset
//   s_cmd_data/valid/ready           command word handshake from host
//   s_data_tdata/tvalid/tready       BC->RT data words from host
//   m_tx_tdata/tsync/tvalid/tready   word stream to core (tsync 1 = cmd/status sync)
//   s_rx_tdata/tsync/terr/tvalid     decoded words from core, no backpressure
//   m_rdata/m_rdata_valid            RT->BC data words to host, one-cycle pulse
//   m_sts_status/result/count        result record: status word, result code, word count
//   m_sts_valid/m_sts_ready          result record handshake
//   busy                             high whenever a message is in progress
//
// Result codes: 0 OK, 1 timeout, 2 rx error, 3 protocol error, 4 short count.

module bc_1553_scheduler #(
    parameter int TIMEOUT_CYCLES = 4000
) (
    input  logic        aclk,
    input  logic        arstn,
    input  logic [15:0] s_cmd_data,
    input  logic        s_cmd_valid,
    output logic        s_cmd_ready,
    input  logic [15:0] s_data_tdata,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    output logic [15:0] m_tx_tdata,
    output logic        m_tx_tsync,
    output logic        m_tx_tvalid,
    input  logic        m_tx_tready,
    input  logic [15:0] s_rx_tdata,
    input  logic        s_rx_tsync,
    input  logic        s_rx_terr,
    input  logic        s_rx_tvalid,
    output logic [15:0] m_rdata,
    output logic        m_rdata_valid,
    output logic [15:0] m_sts_status,
    output logic [2:0]  m_sts_result,
    output logic [5:0]  m_sts_count,
    output logic        m_sts_valid,
    input  logic        m_sts_ready,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_CMD,
        SEND_DATA,
        WAIT_STATUS,
        RECV_DATA,
        REPORT
    } state_t;

    typedef enum logic [2:0] {
        RES_OK      = 3'd0,
        RES_TIMEOUT = 3'd1,
        RES_RX_ERR  = 3'd2,
        RES_PROTO   = 3'd3,
        RES_SHORT   = 3'd4
    } result_t;

    state_t        state;
    state_t        state_next;
    result_t       sts_result;
    result_t       result_next;

    logic [15:0]   cmd_reg;
    logic [5:0]    wc;
    logic [5:0]    count;
    logic [15:0]   status_reg;
    logic [TW-1:0] timer;

    logic          cmd_accept;
    logic          data_hs;
    logic          status_load;
    logic          rdata_load;
    logic          result_load;

    logic [4:0]    rt_addr;
    logic          cmd_tr;
    logic          last_word;
    logic          timer_expired;

    assign rt_addr       = cmd_reg[15:11];
    assign cmd_tr        = cmd_reg[10];
    assign last_word     = ((count + 6'd1) == wc);
    assign timer_expired = (timer == TW'(TIMEOUT_CYCLES));

    assign m_sts_valid  = (state == REPORT);
    assign m_sts_status = status_reg;
    assign m_sts_result = sts_result;
    assign m_sts_count  = count;
    assign busy         = (state != IDLE);

    // State register. Reset drops straight back to IDLE, which abandons any
    // message in flight without producing a result record.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. The transmit side is purely
    // combinational so the SEND_DATA pass-through adds no latency and the
    // transmit valid falls as soon as reset forces the state to IDLE.
    // s_cmd_ready is also gated by arstn so it reads 0 while reset is held.
    // In the receive states an arriving word is examined before the timer,
    // so a word landing on the expiry cycle still counts.
    always_comb begin
        state_next    = state;
        result_next   = RES_OK;
        result_load   = 1'b0;
        cmd_accept    = 1'b0;
        data_hs       = 1'b0;
        status_load   = 1'b0;
        rdata_load    = 1'b0;
        s_cmd_ready   = 1'b0;
        s_data_tready = 1'b0;
        m_tx_tdata    = 16'h0000;
        m_tx_tsync    = 1'b0;
        m_tx_tvalid   = 1'b0;

        case (state)
            IDLE: begin
                s_cmd_ready = arstn;
                if (s_cmd_valid && arstn) begin
                    cmd_accept = 1'b1;
                    state_next = SEND_CMD;
                end
            end

            SEND_CMD: begin
                m_tx_tdata  = cmd_reg;
                m_tx_tsync  = 1'b1;
                m_tx_tvalid = 1'b1;
                if (m_tx_tready) begin
                    state_next = cmd_tr ? WAIT_STATUS : SEND_DATA;
                end
            end

            SEND_DATA: begin
                m_tx_tdata    = s_data_tdata;
                m_tx_tsync    = 1'b0;
                m_tx_tvalid   = s_data_tvalid;
                s_data_tready = m_tx_tready;
                if (s_data_tvalid && m_tx_tready) begin
                    data_hs = 1'b1;
                    if (last_word) begin
                        if (rt_addr == 5'd31) begin
                            state_next  = REPORT;
                            result_load = 1'b1;
                            result_next = RES_OK;
                        end else begin
                            state_next = WAIT_STATUS;
                        end
                    end
                end
            end

            WAIT_STATUS: begin
                if (s_rx_tvalid) begin
                    if (s_rx_terr) begin
                        state_next  = REPORT;
                        result_load = 1'b1;
                        result_next = RES_RX_ERR;
                    end else if (!s_rx_tsync || (s_rx_tdata[15:11] != rt_addr)) begin
                        state_next  = REPORT;
                        result_load = 1'b1;
                        result_next = RES_PROTO;
                    end else begin
                        status_load = 1'b1;
                        if (cmd_tr) begin
                            state_next = RECV_DATA;
                        end else begin
                            state_next  = REPORT;
                            result_load = 1'b1;
                            result_next = RES_OK;
                        end
                    end
                end else if (timer_expired) begin
                    state_next  = REPORT;
                    result_load = 1'b1;
                    result_next = RES_TIMEOUT;
                end
            end

            RECV_DATA: begin
                if (s_rx_tvalid) begin
                    if (s_rx_terr) begin
                        state_next  = REPORT;
                        result_load = 1'b1;
                        result_next = RES_RX_ERR;
                    end else if (s_rx_tsync) begin
                        state_next  = REPORT;
                        result_load = 1'b1;
                        result_next = RES_PROTO;
                    end else begin
                        rdata_load = 1'b1;
                        if (last_word) begin
                            state_next  = REPORT;
                            result_load = 1'b1;
                            result_next = RES_OK;
                        end
                    end
                end else if (timer_expired) begin
                    state_next  = REPORT;
                    result_load = 1'b1;
                    result_next = (count != 6'd0) ? RES_SHORT : RES_TIMEOUT;
                end
            end

            REPORT: begin
                if (m_sts_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Message datapath: latched command, word counts, status word, result
    // code and the response timer. The timer sits at zero outside the two
    // receive states, so it always starts from zero on entry to WAIT_STATUS,
    // and it restarts on every received word.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cmd_reg       <= 16'h0000;
            wc            <= 6'd0;
            count         <= 6'd0;
            status_reg    <= 16'h0000;
            sts_result    <= RES_OK;
            timer         <= '0;
            m_rdata       <= 16'h0000;
            m_rdata_valid <= 1'b0;
        end else begin
            m_rdata_valid <= rdata_load;
            if (rdata_load) begin
                m_rdata <= s_rx_tdata;
            end

            if (cmd_accept) begin
                cmd_reg    <= s_cmd_data;
                wc         <= (s_cmd_data[4:0] == 5'd0) ? 6'd32 : {1'b0, s_cmd_data[4:0]};
                count      <= 6'd0;
                status_reg <= 16'h0000;
                sts_result <= RES_OK;
            end else if (data_hs || rdata_load) begin
                count <= count + 6'd1;
            end

            if (status_load) begin
                status_reg <= s_rx_tdata;
            end

            if (result_load) begin
                sts_result <= result_next;
            end

            if ((state == WAIT_STATUS || state == RECV_DATA) && !s_rx_tvalid) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule
